// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table arbiter.
package bht_pkg;

   typedef logic [1:0] ctr2_t;

   localparam ctr2_t CTR_MAX = 2'b11;
   localparam ctr2_t CTR_MIN = 2'b00;

   // Index width carried in queued update entries; the top's IDX_W must match.
   localparam int BHT_IDX_W = 4;

   typedef enum logic {INIT, RUN} bht_state_t;

   typedef struct packed {
      logic [BHT_IDX_W-1:0] idx;
      logic                 taken;
   } upd_t;

   function automatic ctr2_t ctr_sat_update(ctr2_t c, logic taken);
      ctr2_t r;
      r = c;
      if (taken && (c != CTR_MAX))
         r = c + 2'd1;
      else if (!taken && (c != CTR_MIN))
         r = c - 2'd1;
      return r;
   endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// Synchronous FIFO of pending counter updates, with occupancy count.
module bht_update_fifo
   import bht_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  upd_t         push_data,
   input  logic         pop,
   output upd_t         pop_data,
   output logic         full,
   output logic         empty,
   output logic [PTR_W:0] count
);

   upd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic             do_push;
   logic             do_pop;

   assign full     = (cnt == (PTR_W+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage holds data only; validity is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bht_arbiter.sv
// Two-bit branch counter table with a single access port shared between
// fetch lookups and buffered commit updates, plus post-reset initialisation.
module bht_arbiter
   import bht_pkg::*;
#(
   parameter int    IDX_W      = BHT_IDX_W,
   parameter int    QDEPTH     = 4,
   parameter ctr2_t INIT_STATE = 2'b11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lk_valid,
   input  logic [IDX_W-1:0] lk_idx,
   output logic             lk_ready,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [1:0]       pred_state,
   input  logic             up_valid,
   input  logic [IDX_W-1:0] up_idx,
   input  logic             up_taken,
   output logic             up_ready,
   output logic             init_busy
);

   localparam int CNT_W   = $clog2(QDEPTH) + 1;
   localparam int ENTRIES = 2**IDX_W;

   bht_state_t       state, state_nx;
   logic [IDX_W-1:0] init_cnt;
   ctr2_t            table_q [ENTRIES];

   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   upd_t             fifo_head, up_entry;
   logic             push, pop, do_lookup, tbl_we;
   logic [IDX_W-1:0] wr_idx;
   ctr2_t            wr_data;

   logic             vld_p1;
   ctr2_t            pred_state_p1;

   assign up_entry = '{idx: up_idx, taken: up_taken};
   assign push     = up_valid && up_ready;

   bht_update_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (up_entry),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   // Port arbitration: a full FIFO forces a drain, otherwise lookups win.
   always_comb begin
      state_nx  = state;
      lk_ready  = 1'b0;
      up_ready  = 1'b0;
      do_lookup = 1'b0;
      pop       = 1'b0;
      tbl_we    = 1'b0;
      wr_idx    = init_cnt;
      wr_data   = INIT_STATE;
      unique case (state)
         INIT: begin
            tbl_we = 1'b1;
            if (init_cnt == '1) state_nx = RUN;
         end
         RUN: begin
            up_ready = (fifo_count < CNT_W'(QDEPTH));
            if (fifo_full) begin
               pop = 1'b1;
            end else begin
               lk_ready = 1'b1;
               if (lk_valid)         do_lookup = 1'b1;
               else if (!fifo_empty) pop       = 1'b1;
            end
            if (pop) begin
               tbl_we  = 1'b1;
               wr_idx  = fifo_head.idx;
               wr_data = ctr_sat_update(table_q[fifo_head.idx], fifo_head.taken);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tbl_we) table_q[wr_idx] <= wr_data;
   end

   // Stage p1: lookup result, one cycle after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1        <= 1'b0;
         pred_state_p1 <= CTR_MIN;
      end else begin
         vld_p1 <= do_lookup;
         if (do_lookup) pred_state_p1 <= table_q[lk_idx];
      end
   end

   assign pred_valid = vld_p1;
   assign pred_state = pred_state_p1;
   assign pred_taken = pred_state_p1[1];
   assign init_busy  = (state == INIT);

endmodule
